// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM carrier generator: FSM encoding and period limits.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pwm_state_e;

    localparam int          PERIOD_W       = 16;
    localparam logic [15:0] PERIOD_MIN_DEF = 16'd4;
    localparam logic [15:0] PERIOD_MAX_DEF = 16'h7FFE;

endpackage

// File: rtl/pwm_carrier_gen_if.sv
// Control inputs and carrier status outputs of the PWM carrier generator.
interface pwm_carrier_gen_if;
    import pwm_pkg::*;

    logic                enable_i;
    logic [PERIOD_W-1:0] period_i;
    logic                sync_i;
    logic [PERIOD_W-1:0] local_counter_o;
    logic                sync_phase_o;
    logic [PERIOD_W-1:0] current_period_o;
    logic [PERIOD_W-1:0] next_period_o;
    logic                sync_o;
    logic                running_o;

    modport master (
        output enable_i, period_i, sync_i,
        input  local_counter_o, sync_phase_o, current_period_o,
               next_period_o, sync_o, running_o
    );

    modport slave (
        input  enable_i, period_i, sync_i,
        output local_counter_o, sync_phase_o, current_period_o,
               next_period_o, sync_o, running_o
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a rising-edge detector for an asynchronous strobe.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Decoded straight from flops so the event is seen on the third edge after d_i rises.
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/pwm_carrier_gen.sv
// Up-counting PWM carrier with half-period phase flag, cycle-start pulse and external resync.
module pwm_carrier_gen
    import pwm_pkg::*;
#(
    parameter logic [15:0] PERIOD_MIN = PERIOD_MIN_DEF,
    parameter logic [15:0] PERIOD_MAX = PERIOD_MAX_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pwm_carrier_gen_if.slave    bus
);

    pwm_state_e          state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [PERIOD_W-1:0] cur_q, cur_d;
    logic [PERIOD_W-1:0] nxt_q;
    logic                pulse_q, pulse_d;
    logic                running_q;
    logic [PERIOD_W-1:0] half;
    logic                last;
    logic                sync_evt;

    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        logic [PERIOD_W-1:0] even;
        even = {p[PERIOD_W-1:1], 1'b0};
        if (even < PERIOD_MIN)
            return PERIOD_MIN;
        else if (even > PERIOD_MAX)
            return PERIOD_MAX;
        else
            return even;
    endfunction

    sync_edge_detect u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (bus.sync_i),
        .rise_o (sync_evt)
    );

    assign half = {1'b0, cur_q[PERIOD_W-1:1]};
    assign last = (cnt_q == half - 16'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        cur_d   = cur_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_STOP: begin
                cnt_d   = '0;
                phase_d = 1'b0;
                // nxt_q is zero only in the first cycle after reset; never start on it.
                if (bus.enable_i && (nxt_q != '0)) begin
                    state_d = ST_RUN;
                    cur_d   = nxt_q;
                    pulse_d = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (state_q == ST_RUN && !bus.enable_i)
                    state_d = ST_DRAIN;
                else if (state_q == ST_DRAIN && bus.enable_i)
                    state_d = ST_RUN;

                if (sync_evt) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    cur_d   = nxt_q;
                    pulse_d = 1'b1;
                end else if (last) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        // Cycle start: a drained carrier stops here silently.
                        if (state_q == ST_DRAIN && !bus.enable_i) begin
                            state_d = ST_STOP;
                        end else begin
                            cur_d   = nxt_q;
                            pulse_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_STOP;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            cur_q     <= '0;
            nxt_q     <= '0;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            cur_q     <= cur_d;
            nxt_q     <= clamp_period(bus.period_i);
            pulse_q   <= pulse_d;
            running_q <= (state_d != ST_STOP);
        end
    end

    assign bus.local_counter_o  = cnt_q;
    assign bus.sync_phase_o     = phase_q;
    assign bus.current_period_o = cur_q;
    assign bus.next_period_o    = nxt_q;
    assign bus.sync_o           = pulse_q;
    assign bus.running_o        = running_q;

endmodule
